// File: rtl/load_use_hazard_unit.sv
// Load-use hazard control for the 5-stage RV32I pipeline: combinational stall/flush/freeze outputs, LD_LAT-cycle stall per hazard.
// mem_busy freezes the whole pipeline and holds all internal state; branch flush outranks a fresh hazard.
module load_use_hazard_unit #(
    parameter int          LD_LAT   = 1,
    parameter int          CNT_W    = 16,
    parameter logic [6:0]  OPC_LOAD = 7'b0000011
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr_id,
    input  logic             id_valid,
    input  logic [31:0]      instr_ex,
    input  logic             ex_valid,
    input  logic             mem_busy,
    input  logic             branch_taken,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             bubble_idex,
    output logic             flush_ifid,
    output logic             freeze_all,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {RUN, LDSTALL} state_t;

    localparam logic [3:0]       LAT_M1  = 4'(LD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       count_stall;
    logic       uses_rs1, uses_rs2, hazard;
    logic [4:0] rd_ex, rs1_id, rs2_id;
    logic       unused_fields;

    assign rd_ex  = instr_ex[11:7];
    assign rs1_id = instr_id[19:15];
    assign rs2_id = instr_id[24:20];
    assign unused_fields = ^{instr_id[31:25], instr_id[14:7], instr_ex[31:12]};

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (instr_id[6:0])
            7'b0110011, 7'b0100011, 7'b1100011: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            7'b0010011, 7'b0000011, 7'b1100111: uses_rs1 = 1'b1;
            default: ;
        endcase
    end

    assign hazard = ex_valid && id_valid && (instr_ex[6:0] == OPC_LOAD) && (rd_ex != 5'd0) &&
                    ((uses_rs1 && (rs1_id == rd_ex)) || (uses_rs2 && (rs2_id == rd_ex)));

    always_comb begin
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        bubble_idex = 1'b0;
        flush_ifid  = 1'b0;
        freeze_all  = 1'b0;
        busy        = 1'b0;
        count_stall = 1'b0;
        state_nxt   = state;
        cnt_nxt     = cnt;
        if (rst) begin
            state_nxt = RUN;
        end else if (mem_busy) begin
            freeze_all = 1'b1;
        end else if (state == LDSTALL) begin
            // The load has already left EX, so neither branch nor hazard is looked at here.
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            bubble_idex = 1'b1;
            busy        = 1'b1;
            count_stall = 1'b1;
            cnt_nxt     = cnt - 4'd1;
            if (cnt == 4'd1)
                state_nxt = RUN;
        end else if (branch_taken) begin
            flush_ifid  = 1'b1;
            bubble_idex = 1'b1;
        end else if (hazard) begin
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            bubble_idex = 1'b1;
            count_stall = 1'b1;
            if (LD_LAT > 1) begin
                state_nxt = LDSTALL;
                cnt_nxt   = LAT_M1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            cnt          <= 4'd0;
            stall_cycles <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (count_stall && (stall_cycles != CNT_MAX))
                stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_load_use_hazard_unit.sv
// Scoreboarded bench: three hazard-unit instances (LD_LAT=1, LD_LAT=3, LD_LAT=1 with 2-bit counter) on shared inputs.
module tb_load_use_hazard_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr_id = '0, instr_ex = '0;
    logic        id_valid = 1'b0, ex_valid = 1'b0, mem_busy = 1'b0, branch_taken = 1'b0;

    logic [4:0]  ctl_a, ctl_b, ctl_c;
    logic        busy_a, busy_b, busy_c;
    logic [15:0] sc_a, sc_b;
    logic [1:0]  sc_c;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    load_use_hazard_unit #(.LD_LAT(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .instr_id(instr_id), .id_valid(id_valid), .instr_ex(instr_ex),
        .ex_valid(ex_valid), .mem_busy(mem_busy), .branch_taken(branch_taken),
        .stall_pc(ctl_a[4]), .stall_ifid(ctl_a[3]), .bubble_idex(ctl_a[2]), .flush_ifid(ctl_a[1]),
        .freeze_all(ctl_a[0]), .busy(busy_a), .stall_cycles(sc_a));

    load_use_hazard_unit #(.LD_LAT(3), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .instr_id(instr_id), .id_valid(id_valid), .instr_ex(instr_ex),
        .ex_valid(ex_valid), .mem_busy(mem_busy), .branch_taken(branch_taken),
        .stall_pc(ctl_b[4]), .stall_ifid(ctl_b[3]), .bubble_idex(ctl_b[2]), .flush_ifid(ctl_b[1]),
        .freeze_all(ctl_b[0]), .busy(busy_b), .stall_cycles(sc_b));

    load_use_hazard_unit #(.LD_LAT(1), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .instr_id(instr_id), .id_valid(id_valid), .instr_ex(instr_ex),
        .ex_valid(ex_valid), .mem_busy(mem_busy), .branch_taken(branch_taken),
        .stall_pc(ctl_c[4]), .stall_ifid(ctl_c[3]), .bubble_idex(ctl_c[2]), .flush_ifid(ctl_c[1]),
        .freeze_all(ctl_c[0]), .busy(busy_c), .stall_cycles(sc_c));

    // ctl bit order: {stall_pc, stall_ifid, bubble_idex, flush_ifid, freeze_all}
    localparam logic [4:0] NON = 5'b00000;
    localparam logic [4:0] STL = 5'b11100;
    localparam logic [4:0] FLU = 5'b00110;
    localparam logic [4:0] FRZ = 5'b00001;

    typedef struct {
        int         sel;
        logic [4:0] ctl;
        logic       busy;
        int         cnt;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, opc};
    endfunction

    task automatic step(input int sel, input logic r, input logic [31:0] iid, input logic idv,
                        input logic [31:0] iex, input logic exv, input logic mb, input logic br,
                        input logic [4:0] ectl, input logic ebusy, input int ecnt, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; instr_id = iid; id_valid = idv; instr_ex = iex; ex_valid = exv;
        mem_busy = mb; branch_taken = br;
        e.sel = sel; e.ctl = ectl; e.busy = ebusy; e.cnt = ecnt; e.name = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are combinational, so each cycle's vector is compared at the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [4:0] act_ctl;
            logic       act_busy;
            int         act_cnt;
            e = exp_q.pop_front();
            case (e.sel)
                0:       begin act_ctl = ctl_a; act_busy = busy_a; act_cnt = int'(sc_a); end
                1:       begin act_ctl = ctl_b; act_busy = busy_b; act_cnt = int'(sc_b); end
                default: begin act_ctl = ctl_c; act_busy = busy_c; act_cnt = int'(sc_c); end
            endcase
            compared++;
            if (act_ctl !== e.ctl) begin
                mismatched++;
                $display("FAIL %s ctl: got %b want %b", e.name, act_ctl, e.ctl);
            end
            compared++;
            if (act_busy !== e.busy) begin
                mismatched++;
                $display("FAIL %s busy: got %b want %b", e.name, act_busy, e.busy);
            end
            compared++;
            if (act_cnt != e.cnt) begin
                mismatched++;
                $display("FAIL %s stall_cycles: got %0d want %0d", e.name, act_cnt, e.cnt);
            end
        end
    end

    initial begin
        logic [31:0] lw5, lw0, lw8, add_5_1, add_0_1, addi_7_i5, sw8, jalr5, lui_f5, beq_1_5, addx5, z;
        lw5       = mk(7'b0000011, 5'd5, 5'd1, 5'd0);
        lw0       = mk(7'b0000011, 5'd0, 5'd1, 5'd0);
        lw8       = mk(7'b0000011, 5'd8, 5'd1, 5'd0);
        add_5_1   = mk(7'b0110011, 5'd6, 5'd5, 5'd1);
        add_0_1   = mk(7'b0110011, 5'd6, 5'd0, 5'd1);
        addi_7_i5 = mk(7'b0010011, 5'd6, 5'd7, 5'd5);
        sw8       = mk(7'b0100011, 5'd0, 5'd2, 5'd8);
        jalr5     = mk(7'b1100111, 5'd1, 5'd5, 5'd0);
        lui_f5    = mk(7'b0110111, 5'd6, 5'd5, 5'd5);
        beq_1_5   = mk(7'b1100011, 5'd0, 5'd1, 5'd5);
        addx5     = mk(7'b0110011, 5'd5, 5'd1, 5'd2);
        z         = 32'd0;

        // LD_LAT=1 basic hazard, with reset holding everything quiet first
        step(0, 1, add_5_1, 1, lw5, 1, 0, 0, NON, 0, 0, "a_reset");
        step(0, 0, add_5_1, 1, lw5, 1, 0, 0, STL, 0, 0, "a_hazard");
        step(0, 0, z, 0, z, 0, 0, 0, NON, 0, 1, "a_after");

        // Register-usage decode: no-stall and stall cases
        step(0, 1, z, 0, z, 0, 0, 0, NON, 0, 0, "dec_reset");
        step(0, 0, add_0_1, 1, lw0, 1, 0, 0, NON, 0, 0, "dec_x0");
        step(0, 0, addi_7_i5, 1, lw5, 1, 0, 0, NON, 0, 0, "dec_addi_rs2field");
        step(0, 0, lui_f5, 1, lw5, 1, 0, 0, NON, 0, 0, "dec_lui");
        step(0, 0, add_5_1, 0, lw5, 1, 0, 0, NON, 0, 0, "dec_id_invalid");
        step(0, 0, add_5_1, 1, lw5, 0, 0, 0, NON, 0, 0, "dec_ex_invalid");
        step(0, 0, add_5_1, 1, addx5, 1, 0, 0, NON, 0, 0, "dec_ex_not_load");
        step(0, 0, jalr5, 1, lw5, 1, 0, 0, STL, 0, 0, "dec_jalr_rs1");
        step(0, 0, beq_1_5, 1, lw5, 1, 0, 0, STL, 0, 1, "dec_beq_rs2");
        step(0, 0, z, 0, z, 0, 0, 0, NON, 0, 2, "dec_after");

        // LD_LAT=3 store rs2 hazard; branch during LDSTALL is ignored
        step(1, 1, z, 0, z, 0, 0, 0, NON, 0, 0, "b_reset");
        step(1, 0, sw8, 1, lw8, 1, 0, 0, STL, 0, 0, "b_stall1");
        step(1, 0, z, 0, z, 0, 0, 1, STL, 1, 1, "b_stall2_br");
        step(1, 0, z, 0, z, 0, 0, 0, STL, 1, 2, "b_stall3");
        step(1, 0, z, 0, z, 0, 0, 0, NON, 0, 3, "b_done");

        // LD_LAT=3 with a 2-cycle memory freeze inside the stall
        step(1, 1, z, 0, z, 0, 0, 0, NON, 0, 0, "frz_reset");
        step(1, 0, sw8, 1, lw8, 1, 0, 0, STL, 0, 0, "frz_stall1");
        step(1, 0, z, 0, z, 0, 1, 0, FRZ, 0, 1, "frz_f1");
        step(1, 0, z, 0, z, 0, 1, 1, FRZ, 0, 1, "frz_f2");
        step(1, 0, z, 0, z, 0, 0, 0, STL, 1, 1, "frz_stall2");
        step(1, 0, z, 0, z, 0, 0, 0, STL, 1, 2, "frz_stall3");
        step(1, 0, z, 0, z, 0, 0, 0, NON, 0, 3, "frz_done");

        // Branch beats hazard; mem_busy beats hazard in RUN
        step(1, 1, z, 0, z, 0, 0, 0, NON, 0, 0, "br_reset");
        step(1, 0, add_5_1, 1, lw5, 1, 0, 1, FLU, 0, 0, "br_flush");
        step(1, 0, z, 0, z, 0, 0, 0, NON, 0, 0, "br_after");
        step(1, 0, add_5_1, 1, lw5, 1, 1, 1, FRZ, 0, 0, "mb_over_hazard");
        step(1, 0, z, 0, z, 0, 0, 0, NON, 0, 0, "mb_after");

        // Back-to-back hazards, then reset asserted mid-LDSTALL
        step(1, 1, z, 0, z, 0, 0, 0, NON, 0, 0, "bb_reset");
        step(1, 0, add_5_1, 1, lw5, 1, 0, 0, STL, 0, 0, "bb_h1");
        step(1, 0, z, 0, z, 0, 0, 0, STL, 1, 1, "bb_s2");
        step(1, 0, z, 0, z, 0, 0, 0, STL, 1, 2, "bb_s3");
        step(1, 0, sw8, 1, lw8, 1, 0, 0, STL, 0, 3, "bb_h2");
        step(1, 0, z, 0, z, 0, 0, 0, STL, 1, 4, "bb_h2_s2");
        step(1, 1, add_5_1, 1, lw5, 1, 0, 0, NON, 0, 0, "rst_mid_ldstall");
        step(1, 0, z, 0, z, 0, 0, 0, NON, 0, 0, "rst_after");

        // CNT_W=2 saturation over five separate hazards
        step(2, 1, z, 0, z, 0, 0, 0, NON, 0, 0, "sat_reset");
        for (int i = 0; i < 5; i++) begin
            step(2, 0, add_5_1, 1, lw5, 1, 0, 0, STL, 0, (i < 3) ? i : 3, "sat_hazard");
            step(2, 0, z, 0, z, 0, 0, 0, NON, 0, (i + 1 < 3) ? i + 1 : 3, "sat_idle");
        end

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
